mul_csa_iter: RTL and testbench

Multi-cycle RV32M multiplier (MUL, MULH, MULHSU, MULHU) that sits directly downstream of the 3-input carry-save adder stage. Each cycle it feeds its registered sum/carry pair and one partial product into a 64-bit csa instance. It registers the redundant outputs and applies the carry-vector left shift itself. A final resolve cycle does carry-propagate addition and sign fix-up, and the block hands the 32-bit result to the EX/MEM writeback path.

---
 rtl/mul_pkg.sv | 19 +
 rtl/csa.sv | 15 +
 rtl/mul_csa_iter.sv | 146 ++++++++++++++
 tb/tb_mul_csa_iter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative carry-save RV32M multiplier.
package mul_pkg;

    localparam int unsigned MUL_XLEN = 32;
    localparam int unsigned MUL_ACCW = 2 * MUL_XLEN;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ACC     = 2'b01,
        S_RESOLVE = 2'b10,
        S_DONE    = 2'b11
    } state_e;

endpackage

// File: rtl/csa.sv
// 3:2 carry-save adder; the carry vector is returned unshifted.
module csa #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    assign sum   = x ^ y ^ z;
    assign carry = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/mul_csa_iter.sv
// Multi-cycle RV32M multiplier: shift-add over a carry-save accumulator,
// one carry-propagate add plus sign fix-up at the end.
module mul_csa_iter
    import mul_pkg::*;
#(
    parameter int unsigned XLEN = MUL_XLEN,
    parameter int unsigned ACCW = MUL_ACCW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    state_e state, state_d;

    logic            sign_neg;
    logic [1:0]      op_r;
    logic [ACCW-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [ACCW-1:0] sum_r;
    logic [ACCW-1:0] carry_r;

    logic            accept_c;
    logic            acc_c;
    logic            resolve_c;
    logic            last_c;
    logic            in_ready_d;
    logic            out_valid_d;
    logic            sa_c;
    logic            sb_c;
    logic [XLEN-1:0] mag_a_c;
    logic [XLEN-1:0] mag_b_c;
    logic [XLEN-1:0] mplier_shr_c;
    logic [ACCW-1:0] carry_sh_c;
    logic [ACCW-1:0] pp_c;
    logic [ACCW-1:0] csa_sum;
    logic [ACCW-1:0] csa_carry;
    logic [ACCW-1:0] prod_c;
    logic [ACCW-1:0] res_c;
    logic            unused_carry_msb;

    // Operand signs and magnitudes; 0x80000000 negates to itself, read as unsigned.
    assign sa_c    = (in_op != MUL_OP_MULHU) & in_a[XLEN-1];
    assign sb_c    = ((in_op == MUL_OP_MUL) | (in_op == MUL_OP_MULH)) & in_b[XLEN-1];
    assign mag_a_c = sa_c ? XLEN'(-in_a) : in_a;
    assign mag_b_c = sb_c ? XLEN'(-in_b) : in_b;

    assign mplier_shr_c = mplier >> 1;
    assign last_c       = (mplier_shr_c == '0);
    assign carry_sh_c   = {carry_r[ACCW-2:0], 1'b0};
    assign pp_c         = mplier[0] ? mcand : '0;

    csa #(.WIDTH(ACCW)) u_csa (
        .x     (sum_r),
        .y     (carry_sh_c),
        .z     (pp_c),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    assign prod_c           = sum_r + carry_sh_c;
    assign res_c            = sign_neg ? ACCW'(-prod_c) : prod_c;
    assign unused_carry_msb = carry_r[ACCW-1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (in_valid && in_ready) state_d = S_ACC;
                S_ACC:     if (last_c)               state_d = S_RESOLVE;
                S_RESOLVE:                           state_d = S_DONE;
                S_DONE:    if (out_valid && out_ready) state_d = S_IDLE;
                default:                             state_d = S_IDLE;
            endcase
        end
    end

    // Control strobes and next values of the registered handshakes
    always_comb begin
        accept_c    = 1'b0;
        acc_c       = 1'b0;
        resolve_c   = 1'b0;
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        if (!flush) begin
            accept_c  = (state == S_IDLE) && in_valid && in_ready;
            acc_c     = (state == S_ACC);
            resolve_c = (state == S_RESOLVE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            if (resolve_c)
                out_result <= (op_r == MUL_OP_MUL) ? res_c[XLEN-1:0] : res_c[ACCW-1:XLEN];
        end
    end

    // Datapath: latch operands on accept, one partial product per ACC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_neg <= 1'b0;
            op_r     <= MUL_OP_MUL;
            mcand    <= '0;
            mplier   <= '0;
            sum_r    <= '0;
            carry_r  <= '0;
        end else if (accept_c) begin
            sign_neg <= sa_c ^ sb_c;
            op_r     <= in_op;
            mcand    <= ACCW'(mag_a_c);
            mplier   <= mag_b_c;
            sum_r    <= '0;
            carry_r  <= '0;
        end else if (acc_c) begin
            sum_r    <= csa_sum;
            carry_r  <= csa_carry;
            mcand    <= mcand << 1;
            mplier   <= mplier_shr_c;
        end
    end

endmodule

// File: tb/tb_mul_csa_iter.sv
// Bench for mul_csa_iter: directed corner cases plus random ops against a 64-bit product model.
module tb_mul_csa_iter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    int n_checks;
    int n_errors;

    mul_csa_iter dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: full product mod 2^64 from sign- or zero-extended operands
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = (op == 2'd3) ? {32'd0, a} : {{32{a[31]}}, a};
        xb = (op[1] == 1'b1) ? {32'd0, b} : {{32{b[31]}}, b};
        p  = xa * xb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Cycles from accept edge to out_valid: one per significant bit of |b|, min 1, plus resolve
    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] m;
        int n;
        m = (op[1] == 1'b0 && b[31]) ? 32'(-b) : b;
        n = 0;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        if (n < 1) n = 1;
        return n + 1;
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        int cyc;
        logic [31:0] exp_res;
        exp_res = ref_mul(op, a, b);
        cyc = 0;
        while (!in_ready && cyc < 60) begin
            @(posedge clk); #1; cyc++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = 2'($urandom); in_a = $urandom; in_b = $urandom;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        check("latency", 64'(cyc), 64'(ref_lat(op, b)));
        check("result", 64'(out_result), 64'(exp_res));
        check("busy_in_ready", 64'(in_ready), 64'd0);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", 64'(out_result), 64'(exp_res));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handoff_valid", 64'(out_valid), 64'd0);
        check("handoff_in_ready", 64'(in_ready), 64'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0000_0000;
            1:       v = 32'h0000_0001;
            2:       v = 32'h8000_0000;
            3:       v = 32'hFFFF_FFFF;
            4:       v = 32'($urandom_range(0, 255));
            5:       v = 32'($urandom) | 32'h8000_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic seen;
        n_checks = 0; n_errors = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 2'd0; in_a = '0; in_b = '0;
        #8;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        #4 rst = 1'b0;
        @(posedge clk); #1;

        do_op(2'd0, 32'd7, 32'd6, 0);
        do_op(2'd1, 32'h8000_0000, 32'h8000_0000, 0);
        do_op(2'd3, 32'h8000_0000, 32'h8000_0000, 0);
        do_op(2'd2, 32'h8000_0000, 32'h8000_0000, 0);
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(2'd3, 32'h1234_5678, 32'd0, 5);
        do_op(2'd0, 32'hDEAD_BEEF, 32'd1, 1);

        // Flush in the 10th ACC cycle of a full-length op
        in_valid = 1'b1; in_op = 2'd3; in_a = $urandom; in_b = 32'h8000_0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check("flush_no_valid", 64'(seen), 64'd0);
        do_op(2'd0, 32'd3, 32'd5, 0);

        // Flush together with in_valid in IDLE must not accept
        flush = 1'b1; in_valid = 1'b1; in_op = 2'd0; in_a = 32'd9; in_b = 32'd9;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (5) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check("flush_idle_no_valid", 64'(seen), 64'd0);

        // Asynchronous reset mid-ACC, out_result non-zero beforehand
        in_valid = 1'b1; in_op = 2'd3; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_result", 64'(out_result), 64'd0);
        #2 rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check("arst_no_valid", 64'(seen), 64'd0);
        do_op(2'd1, 32'hFFFF_FFF9, 32'd6, 0);

        for (int i = 0; i < 1500; i++)
            do_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                  ($urandom_range(0, 7) == 0) ? 2 : 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
